clint_cfg_sequencer: RTL and testbench
======================================

CLINT_CFG_SEQUENCER -- requirements
Module: clint_cfg_sequencer

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 16, M_AXI address width.
REQ-002 SHALL have parameter C_NUM_REGS, default 4, number of consecutive 32-bit CLINT registers programmed (1..16).
REQ-003 SHALL have parameter C_BASE_ADDR, default 0, byte address of the first register.
REQ-004 SHALL have port ACLK, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port ARESETN, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, begin one program+verify run.
REQ-007 SHALL have port cfg_data, input, 32*C_NUM_REGS, word i for register i.
REQ-008 SHALL have port busy, output, 1, run in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse at end of run.
REQ-010 SHALL have port fail, output, 1, result of last run, held until next accepted start.
REQ-011 SHALL have port err_idx, output, 4, index of the failing register, held with fail.
REQ-012 SHALL have ports M_AXI_AWADDR out C_ADDR_WIDTH, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1, write address channel.
REQ-013 SHALL have ports M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1, write data channel.
REQ-014 SHALL have ports M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1, write response channel.
REQ-015 SHALL have ports M_AXI_ARADDR out C_ADDR_WIDTH, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1, read address channel.
REQ-016 SHALL have ports M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1, read data channel.

Function
REQ-017 SHALL implement states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, FINISH.
REQ-018 IDLE: start=1 SHALL capture cfg_data into an internal register, clear fail/err_idx, set index=0, set busy, enter WR_REQ next cycle; start while busy SHALL be ignored.
REQ-019 WR_REQ: SHALL assert AWVALID and WVALID together, AWADDR=C_BASE_ADDR+4*index, WDATA=captured word[index], WSTRB=4'hF.
REQ-020 AWVALID and WVALID SHALL each deassert the cycle after its own handshake, independently, and SHALL not drop before handshake; both accepted -> WR_RESP.
REQ-021 WR_RESP: BREADY=1; on BVALID, BRESP=OKAY -> next index or, after the last, index=0 and RD_REQ; BRESP!=OKAY -> fail=1, err_idx=index, FINISH.
REQ-022 RD_REQ: ARVALID=1, ARADDR=C_BASE_ADDR+4*index, held until ARREADY; then RD_DATA.
REQ-023 RD_DATA: RREADY=1; on RVALID, RRESP!=OKAY or RDATA!=captured word[index] -> fail=1, err_idx=index, FINISH; else next index or FINISH after the last.
REQ-024 At most one outstanding AXI transaction at any time; no read issued before all write responses received.
REQ-025 FINISH: done=1 for exactly one cycle, busy=0 same cycle, return to IDLE.
REQ-026 Address arithmetic SHALL be modulo 2^C_ADDR_WIDTH.
REQ-027 Handshakes with READY asserted in the same cycle as VALID SHALL complete in that cycle; minimum run latency = 4*C_NUM_REGS+2 cycles from start to done with zero-wait slave.

Reset
REQ-028 ARESETN=0 SHALL immediately force state IDLE and drive all VALID/READY outputs, busy, done, fail, err_idx to 0, regardless of in-progress transaction.
REQ-029 After ARESETN deassertion the block SHALL remain IDLE until a start.

Verification
REQ-030 Zero-wait slave, cfg_data={4,3,2,1}: writes 1,2,3,4 to 0x0,0x4,0x8,0xC then reads; done at cycle 18, fail=0.
REQ-031 AWREADY delayed 3 cycles, WREADY immediate: WVALID drops after 1 cycle, AWVALID held 4 cycles, single BREADY handshake per write.
REQ-032 Slave returns RDATA 0xDEAD for register 2: fail=1, err_idx=2, done pulse, no read of register 3.
REQ-033 BRESP=SLVERR on write 1: fail=1, err_idx=1, no further AW/AR issued.
REQ-034 ARESETN pulsed low during RD_DATA: all outputs 0 next edge-independent; new start runs full sequence cleanly.
REQ-035 start held high for whole run: exactly one run; new run only when start seen in IDLE after FINISH.

Source files
------------

// File: rtl/clint_cfg_sequencer_if.sv
// AXI4-Lite master bundle for the CLINT configuration sequencer.
// Member names mirror the M_AXI_* bus signal names.
interface clint_cfg_sequencer_if #(
    parameter int C_ADDR_WIDTH = 16
) ();
    logic [C_ADDR_WIDTH-1:0] M_AXI_AWADDR;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;
    logic [31:0]             M_AXI_WDATA;
    logic [3:0]              M_AXI_WSTRB;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;
    logic [C_ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;
    logic [31:0]             M_AXI_RDATA;
    logic [1:0]              M_AXI_RRESP;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/clint_cfg_sequencer.sv
// Programs a block of CLINT registers over AXI4-Lite, then reads
// each one back and flags the first register that does not verify.
module clint_cfg_sequencer #(
    parameter int              C_ADDR_WIDTH = 16,
    parameter int              C_NUM_REGS   = 4,
    parameter longint unsigned C_BASE_ADDR  = 0
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    start,
    input  logic [32*C_NUM_REGS-1:0] cfg_data,
    output logic                    busy,
    output logic                    done,
    output logic                    fail,
    output logic [3:0]              err_idx,
    clint_cfg_sequencer_if.master   m_axi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_DATA,
        S_FINISH
    } state_t;

    localparam logic [3:0] LP_LAST = 4'(C_NUM_REGS - 1);
    localparam logic [1:0] LP_OKAY = 2'b00;
    localparam logic [C_ADDR_WIDTH-1:0] LP_BASE =
        C_ADDR_WIDTH'(C_BASE_ADDR);

    state_t            r_state;
    logic [3:0]        r_idx;
    logic [15:0][31:0] r_cfg;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_bready;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_busy;
    logic              r_done;
    logic              r_fail;
    logic [3:0]        r_err_idx;

    logic [5:0]              w_off;
    logic [C_ADDR_WIDTH-1:0] w_addr;
    logic [31:0]             w_word;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_aw_ok;
    logic                    w_w_ok;
    logic                    w_last;
    logic                    w_rd_bad;

    // Address wraps naturally at C_ADDR_WIDTH bits.
    assign w_off  = {r_idx, 2'b00};
    assign w_addr = LP_BASE + C_ADDR_WIDTH'(w_off);
    assign w_word = r_cfg[r_idx];
    assign w_last = (r_idx == LP_LAST);

    assign w_aw_hs = r_awvalid & m_axi.M_AXI_AWREADY;
    assign w_w_hs  = r_wvalid & m_axi.M_AXI_WREADY;
    assign w_aw_ok = ~r_awvalid | m_axi.M_AXI_AWREADY;
    assign w_w_ok  = ~r_wvalid | m_axi.M_AXI_WREADY;

    assign w_rd_bad = (m_axi.M_AXI_RRESP != LP_OKAY) |
                      (m_axi.M_AXI_RDATA != w_word);

    assign m_axi.M_AXI_AWADDR  = w_addr;
    assign m_axi.M_AXI_AWVALID = r_awvalid;
    assign m_axi.M_AXI_WDATA   = w_word;
    assign m_axi.M_AXI_WSTRB   = 4'hF;
    assign m_axi.M_AXI_WVALID  = r_wvalid;
    assign m_axi.M_AXI_BREADY  = r_bready;
    assign m_axi.M_AXI_ARADDR  = w_addr;
    assign m_axi.M_AXI_ARVALID = r_arvalid;
    assign m_axi.M_AXI_RREADY  = r_rready;

    assign busy    = r_busy;
    assign done    = r_done;
    assign fail    = r_fail;
    assign err_idx = r_err_idx;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_cfg     <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fail    <= 1'b0;
            r_err_idx <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cfg     <= 512'(cfg_data);
                        r_fail    <= 1'b0;
                        r_err_idx <= '0;
                        r_idx     <= '0;
                        r_busy    <= 1'b1;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    // AW and W retire independently; move on once both have.
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs)  r_wvalid  <= 1'b0;
                    if (w_aw_ok && w_w_ok) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (m_axi.M_AXI_BVALID) begin
                        r_bready <= 1'b0;
                        if (m_axi.M_AXI_BRESP != LP_OKAY) begin
                            r_fail    <= 1'b1;
                            r_err_idx <= r_idx;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_FINISH;
                        end else if (w_last) begin
                            r_idx     <= '0;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_REQ;
                        end else begin
                            r_idx     <= r_idx + 4'd1;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (m_axi.M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (m_axi.M_AXI_RVALID) begin
                        r_rready <= 1'b0;
                        if (w_rd_bad) begin
                            r_fail    <= 1'b1;
                            r_err_idx <= r_idx;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_FINISH;
                        end else if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_idx     <= r_idx + 4'd1;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_REQ;
                        end
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clint_cfg_sequencer.sv
// Bench for clint_cfg_sequencer: AXI4-Lite slave with tunable delays
// and fault injection, checked against a run-level reference model.
module tb_clint_cfg_sequencer;
    localparam int N  = 4;
    localparam int AW = 16;

    logic           ACLK = 1'b0;
    logic           ARESETN = 1'b0;
    logic           start = 1'b0;
    logic [32*N-1:0] cfg_data = '0;
    logic           busy;
    logic           done;
    logic           fail;
    logic [3:0]     err_idx;

    clint_cfg_sequencer_if #(.C_ADDR_WIDTH(AW)) axi ();

    clint_cfg_sequencer #(
        .C_ADDR_WIDTH(AW),
        .C_NUM_REGS  (N),
        .C_BASE_ADDR (0)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .start   (start),
        .cfg_data(cfg_data),
        .busy    (busy),
        .done    (done),
        .fail    (fail),
        .err_idx (err_idx),
        .m_axi   (axi.master)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_fail = 0;

    // slave configuration: *_fix >= 0 is a fixed delay, -1 is random 0..dmax
    int dmax = 0;
    int aw_fix = 0, w_fix = 0, ar_fix = 0, b_fix = 0, r_fix = 0;
    int bad_wr = -1, bad_rdata = -1, bad_rresp = -1;

    int awcnt, wcnt, arcnt, bwait, rwait;
    int aw_run, w_run, b_hs, prot_viol;
    logic aw_got, w_got, r_pend;
    logic [AW-1:0] aw_l, ar_l;
    logic [31:0]   wd_l;
    logic [31:0]   mem [16];
    logic prev_aw_stall, prev_w_stall, prev_ar_stall;

    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [AW-1:0] rd_addr_q[$];
    int            aw_len_q[$];
    int            w_len_q[$];

    function automatic int pick(input int f);
        if (f >= 0) return f;
        return int'($urandom_range(dmax, 0));
    endfunction

    logic aw_hs, w_hs, ar_hs, aw_have, w_have, r_have;
    logic [AW-1:0] cur_aw, cur_ar;
    logic [31:0]   cur_wd;
    assign aw_hs   = axi.M_AXI_AWVALID & axi.M_AXI_AWREADY;
    assign w_hs    = axi.M_AXI_WVALID & axi.M_AXI_WREADY;
    assign ar_hs   = axi.M_AXI_ARVALID & axi.M_AXI_ARREADY;
    assign aw_have = aw_got | aw_hs;
    assign w_have  = w_got | w_hs;
    assign r_have  = r_pend | ar_hs;
    assign cur_aw  = aw_hs ? axi.M_AXI_AWADDR : aw_l;
    assign cur_wd  = w_hs ? axi.M_AXI_WDATA : wd_l;
    assign cur_ar  = ar_hs ? axi.M_AXI_ARADDR : ar_l;

    assign axi.M_AXI_AWREADY = (awcnt == 0);
    assign axi.M_AXI_WREADY  = (wcnt == 0);
    assign axi.M_AXI_ARREADY = (arcnt == 0);

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awcnt <= 0; wcnt <= 0; arcnt <= 0;
        end else begin
            awcnt <= (axi.M_AXI_AWVALID && awcnt != 0) ? awcnt - 1 : pick(aw_fix);
            wcnt  <= (axi.M_AXI_WVALID && wcnt != 0) ? wcnt - 1 : pick(w_fix);
            arcnt <= (axi.M_AXI_ARVALID && arcnt != 0) ? arcnt - 1 : pick(ar_fix);
        end
    end

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
            bwait <= 0; rwait <= 0; aw_run <= 0; w_run <= 0;
            axi.M_AXI_BVALID <= 1'b0; axi.M_AXI_BRESP <= 2'b00;
            axi.M_AXI_RVALID <= 1'b0; axi.M_AXI_RRESP <= 2'b00;
            axi.M_AXI_RDATA <= '0;
        end else begin
            if (aw_hs) aw_l <= axi.M_AXI_AWADDR;
            if (w_hs)  wd_l <= axi.M_AXI_WDATA;
            if (ar_hs) ar_l <= axi.M_AXI_ARADDR;
            if (axi.M_AXI_AWVALID) begin
                if (axi.M_AXI_AWREADY) begin
                    aw_len_q.push_back(aw_run + 1); aw_run <= 0;
                end else aw_run <= aw_run + 1;
            end
            if (axi.M_AXI_WVALID) begin
                if (axi.M_AXI_WREADY) begin
                    w_len_q.push_back(w_run + 1); w_run <= 0;
                end else w_run <= w_run + 1;
            end
            if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) begin
                axi.M_AXI_BVALID <= 1'b0; b_hs <= b_hs + 1;
            end
            if (aw_have && w_have) begin
                if (bwait == 0) begin
                    axi.M_AXI_BVALID <= 1'b1;
                    axi.M_AXI_BRESP <= (int'(cur_aw[5:2]) == bad_wr) ? 2'b10 : 2'b00;
                    mem[cur_aw[5:2]] <= cur_wd;
                    wr_addr_q.push_back(cur_aw);
                    wr_data_q.push_back(cur_wd);
                    aw_got <= 1'b0; w_got <= 1'b0;
                    bwait <= pick(b_fix);
                end else begin
                    bwait <= bwait - 1; aw_got <= 1'b1; w_got <= 1'b1;
                end
            end else begin
                aw_got <= aw_have; w_got <= w_have;
            end
            if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) axi.M_AXI_RVALID <= 1'b0;
            if (r_have) begin
                if (rwait == 0) begin
                    axi.M_AXI_RVALID <= 1'b1;
                    axi.M_AXI_RDATA <= (int'(cur_ar[5:2]) == bad_rdata) ?
                                       32'hDEAD : mem[cur_ar[5:2]];
                    axi.M_AXI_RRESP <= (int'(cur_ar[5:2]) == bad_rresp) ? 2'b10 : 2'b00;
                    rd_addr_q.push_back(cur_ar);
                    r_pend <= 1'b0;
                    rwait <= pick(r_fix);
                end else begin
                    rwait <= rwait - 1; r_pend <= 1'b1;
                end
            end
        end
    end

    // protocol monitor: VALID must hold until accepted, one transaction at a time
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            prev_aw_stall <= 1'b0; prev_w_stall <= 1'b0; prev_ar_stall <= 1'b0;
        end else begin
            prev_aw_stall <= axi.M_AXI_AWVALID & ~axi.M_AXI_AWREADY;
            prev_w_stall  <= axi.M_AXI_WVALID & ~axi.M_AXI_WREADY;
            prev_ar_stall <= axi.M_AXI_ARVALID & ~axi.M_AXI_ARREADY;
            if ((prev_aw_stall && !axi.M_AXI_AWVALID) ||
                (prev_w_stall && !axi.M_AXI_WVALID) ||
                (prev_ar_stall && !axi.M_AXI_ARVALID) ||
                (axi.M_AXI_ARVALID && (axi.M_AXI_AWVALID || axi.M_AXI_WVALID ||
                                      aw_got || w_got || axi.M_AXI_BVALID)) ||
                ((axi.M_AXI_AWVALID || axi.M_AXI_WVALID) &&
                 (r_pend || axi.M_AXI_RVALID)))
                prot_viol <= prot_viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int b_base;

    task automatic do_run(input logic [32*N-1:0] cfg, input bit hold, input bit glitch,
                          output int cyc, output bit to);
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        aw_len_q.delete(); w_len_q.delete();
        b_base = b_hs;
        cfg_data = cfg;
        start = 1'b1;
        cyc = 1;
        to = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge ACLK);
            cyc++;
            if (!hold) start = 1'b0;
            if (k == 0) chk("run_busy_set", 32'(busy), 32'd1);
            if (glitch && k == 4) begin start = 1'b1; cfg_data = ~cfg; end
            if (glitch && k == 5) cfg_data = cfg;
            if (done) begin to = 1'b0; break; end
        end
        start = 1'b0;
        chk("run_timeout", 32'(to), 32'd0);
        chk("done_busy_low", 32'(busy), 32'd0);
        @(negedge ACLK);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("no_restart", 32'(busy), 32'd0);
    endtask

    // Reference model: expected transfer counts and outcome of one run.
    task automatic check_run(input string tag, input logic [32*N-1:0] cfg);
        int nw, nr, eidx;
        bit ef;
        logic [31:0] word;
        nw = N; nr = N; ef = 1'b0; eidx = 0;
        if (bad_wr >= 0 && bad_wr < N) begin
            nw = bad_wr + 1; nr = 0; ef = 1'b1; eidx = bad_wr;
        end else begin
            for (int j = 0; j < N; j++) begin
                word = cfg[32*j +: 32];
                if (j == bad_rresp || (j == bad_rdata && word != 32'hDEAD)) begin
                    nr = j + 1; ef = 1'b1; eidx = j;
                    break;
                end
            end
        end
        chk({tag, "_fail"}, 32'(fail), 32'(ef));
        chk({tag, "_err_idx"}, 32'(err_idx), 32'(eidx));
        chk({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(nw));
        chk({tag, "_nb"}, 32'(b_hs - b_base), 32'(nw));
        chk({tag, "_nrd"}, 32'(rd_addr_q.size()), 32'(nr));
        for (int i = 0; i < nw; i++) begin
            if (i < wr_addr_q.size()) begin
                chk({tag, "_wr_addr"}, 32'(wr_addr_q[i]), 32'(4 * i));
                chk({tag, "_wr_data"}, wr_data_q[i], cfg[32*i +: 32]);
            end
        end
        for (int i = 0; i < nr; i++)
            if (i < rd_addr_q.size())
                chk({tag, "_rd_addr"}, 32'(rd_addr_q[i]), 32'(4 * i));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_awvalid"}, 32'(axi.M_AXI_AWVALID), 32'd0);
        chk({tag, "_wvalid"}, 32'(axi.M_AXI_WVALID), 32'd0);
        chk({tag, "_bready"}, 32'(axi.M_AXI_BREADY), 32'd0);
        chk({tag, "_arvalid"}, 32'(axi.M_AXI_ARVALID), 32'd0);
        chk({tag, "_rready"}, 32'(axi.M_AXI_RREADY), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_fail"}, 32'(fail), 32'd0);
        chk({tag, "_err_idx"}, 32'(err_idx), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32*N-1:0] cfg;
        int  cyc, sel;
        bit  to;

        b_hs = 0;
        prot_viol = 0;
        repeat (3) @(negedge ACLK);
        chk_quiet("reset");
        ARESETN = 1'b1;
        repeat (6) @(negedge ACLK);
        chk_quiet("idle_after_reset");

        // zero-wait slave, words 1..4
        cfg = {32'd4, 32'd3, 32'd2, 32'd1};
        do_run(cfg, 1'b0, 1'b0, cyc, to);
        chk("zw_latency", 32'(cyc), 32'(4 * N + 2));
        check_run("zw", cfg);

        // AWREADY 3 cycles late, WREADY immediate
        aw_fix = 3;
        cfg = {$urandom, $urandom, $urandom, $urandom};
        do_run(cfg, 1'b0, 1'b0, cyc, to);
        chk("awdly_latency", 32'(cyc), 32'(4 * N + 2 + 3 * N));
        check_run("awdly", cfg);
        chk("awdly_naw", 32'(aw_len_q.size()), 32'(N));
        chk("awdly_nw", 32'(w_len_q.size()), 32'(N));
        foreach (aw_len_q[i]) chk("awdly_aw_len", 32'(aw_len_q[i]), 32'd4);
        foreach (w_len_q[i]) chk("awdly_w_len", 32'(w_len_q[i]), 32'd1);
        aw_fix = 0;

        // bad read data on register 2
        bad_rdata = 2;
        cfg = {32'h44, 32'h33, 32'h22, 32'h11};
        do_run(cfg, 1'b0, 1'b0, cyc, to);
        check_run("rdbad", cfg);
        bad_rdata = -1;

        // SLVERR on write 1
        bad_wr = 1;
        cfg = {$urandom, $urandom, $urandom, $urandom};
        do_run(cfg, 1'b0, 1'b0, cyc, to);
        check_run("wrerr", cfg);
        bad_wr = -1;

        // reset asserted while waiting in RD_DATA
        r_fix = 6;
        cfg = {$urandom, $urandom, $urandom, $urandom};
        cfg_data = cfg;
        start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (axi.M_AXI_RREADY) begin to = 1'b0; break; end
            @(negedge ACLK);
        end
        chk("rst_reach_rd", 32'(to), 32'd0);
        #2 ARESETN = 1'b0;
        #1 chk_quiet("async_rst");
        @(negedge ACLK);
        ARESETN = 1'b1;
        r_fix = 0;
        repeat (3) @(negedge ACLK);
        chk_quiet("post_rst_idle");
        cfg = {$urandom, $urandom, $urandom, $urandom};
        do_run(cfg, 1'b0, 1'b0, cyc, to);
        chk("post_rst_latency", 32'(cyc), 32'(4 * N + 2));
        check_run("post_rst", cfg);

        // start held high for the whole run, plus a stray start mid-run
        cfg = {$urandom, $urandom, $urandom, $urandom};
        do_run(cfg, 1'b1, 1'b1, cyc, to);
        chk("hold_latency", 32'(cyc), 32'(4 * N + 2));
        check_run("hold", cfg);

        // randomized delays, data, faults and stray starts
        dmax = 3;
        aw_fix = -1; w_fix = -1; ar_fix = -1; b_fix = -1; r_fix = -1;
        for (int t = 0; t < 14; t++) begin
            cfg = {$urandom, $urandom, $urandom, $urandom};
            sel = int'($urandom_range(3, 0));
            bad_wr    = (sel == 1) ? int'($urandom_range(N - 1, 0)) : -1;
            bad_rdata = (sel == 2) ? int'($urandom_range(N - 1, 0)) : -1;
            bad_rresp = (sel == 3) ? int'($urandom_range(N - 1, 0)) : -1;
            do_run(cfg, 1'b0, 1'($urandom_range(1, 0)), cyc, to);
            check_run("rand", cfg);
            repeat (int'($urandom_range(3, 0))) @(negedge ACLK);
        end

        chk("protocol_violations", 32'(prot_viol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
